// File: rtl/instr_feeder_if.sv
// Upstream instruction handshake: the producer offers an 8-bit packed word
// with in_valid, and the feeder answers with in_ready.
interface instr_feeder_if;
  logic       in_valid;
  logic [7:0] in_word;
  logic       in_ready;

  // Producer side.
  modport master (output in_valid, output in_word, input in_ready);
  // Feeder side.
  modport slave  (input in_valid, input in_word, output in_ready);
endinterface

// File: rtl/instr_feeder.sv
// Instruction feeder: buffers packed words in a small circular FIFO, pops one
// per cycle unless held, filters out invalid ops and mode-0 writes that would
// hit a full cache, and presents registered instructions (or bubbles) to the
// downstream calculator. Saturating counters track issued and dropped words.
module instr_feeder #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  instr_feeder_if.slave          up,
  input  logic                   hold,
  input  logic                   cache_full,
  output logic                   mode,
  output logic [2:0]             opCode,
  output logic [3:0]             value,
  output logic                   issue,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic [CNT_W-1:0]       issue_cnt,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int            AW         = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(DEPTH);
  // A bubble looks like a mode-0 invalid op, which downstream never writes.
  localparam logic [7:0]    BUBBLE     = 8'b0_011_0000;

  typedef enum logic [1:0] {
    ACT_BUBBLE,
    ACT_ISSUE,
    ACT_DROP
  } act_e;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [7:0]    head;
  act_e          act;

  // A full FIFO refuses the push even when a pop frees a slot this cycle.
  assign up.in_ready = (fifo_level < FULL_LEVEL);
  assign push        = up.in_valid && up.in_ready;
  assign pop         = (fifo_level != '0) && !hold;
  assign head        = mem[rd_ptr];

  // Classify the word leaving the FIFO this cycle.
  always_comb begin
    // NOTE: act gets a default before any branch, so no path can leave it unassigned and infer a latch.
    act = ACT_BUBBLE;
    if (pop) begin
      if (!head[7] && ((head[5:4] == 2'b11) || cache_full)) begin
        act = ACT_DROP;
      end else begin
        act = ACT_ISSUE;
      end
    end
  end

  // Word storage, written at the tail on every accepted push.
  // NOTE: storage has no reset; fifo_level alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= up.in_word;
    end
  end

  // Circular pointers and occupancy; push and pop together leave the level unchanged.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values regardless of statement order.
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: ;
      endcase
    end
  end

  // Registered instruction to the calculator: the popped word on issue, else a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {mode, opCode, value} <= BUBBLE;
      issue                 <= 1'b0;
    end else begin
      {mode, opCode, value} <= (act == ACT_ISSUE) ? head : BUBBLE;
      issue                 <= (act == ACT_ISSUE);
    end
  end

  // Saturating issue/drop counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt  <= '0;
      issue_cnt <= '0;
    end else begin
      if ((act == ACT_DROP) && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
      if ((act == ACT_ISSUE) && (issue_cnt != '1)) begin
        issue_cnt <= issue_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_feeder.sv
// Self-checking bench for instr_feeder: a directed vector table, hand-written
// corner sequences (full FIFO, hold/drain, mid-run reset), a random phase and
// a counter-saturation run, all compared against a queue-based reference model.
module tb_instr_feeder;

  localparam int         DEPTH   = 8;
  localparam int         CNT_W   = 8;
  localparam int         CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [7:0] BUBBLE  = 8'h30;

  logic                   clk;
  logic                   reset;
  logic                   hold;
  logic                   cache_full;
  logic                   mode;
  logic [2:0]             opCode;
  logic [3:0]             value;
  logic                   issue;
  logic [CNT_W-1:0]       drop_cnt;
  logic [CNT_W-1:0]       issue_cnt;
  logic [$clog2(DEPTH):0] fifo_level;

  instr_feeder_if bus ();

  instr_feeder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .up         (bus),
    .hold       (hold),
    .cache_full (cache_full),
    .mode       (mode),
    .opCode     (opCode),
    .value      (value),
    .issue      (issue),
    .drop_cnt   (drop_cnt),
    .issue_cnt  (issue_cnt),
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queued words plus the expected registered outputs.
  logic [7:0] q[$];
  logic [7:0] m_out;
  logic       m_issue;
  int         m_drop;
  int         m_icnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_out   = BUBBLE;
    m_issue = 1'b0;
    m_drop  = 0;
    m_icnt  = 0;
  endtask

  task automatic compare_all(input string name);
    check({name, "_out"},   {mode, opCode, value}, m_out);
    check({name, "_issue"}, issue, m_issue);
    check({name, "_level"}, fifo_level, q.size());
    check({name, "_drop"},  drop_cnt, m_drop);
    check({name, "_icnt"},  issue_cnt, m_icnt);
    check({name, "_ready"}, bus.in_ready, (q.size() < DEPTH));
  endtask

  // Apply inputs for one edge, advance the model, then compare just after the edge.
  task automatic step(input string name, input logic v, input logic [7:0] w,
                      input logic h, input logic cf);
    logic       do_pop;
    logic       do_push;
    logic [7:0] hd;
    bus.in_valid = v;
    bus.in_word  = w;
    hold         = h;
    cache_full   = cf;
    @(posedge clk);
    do_pop  = (q.size() > 0) && !h;
    do_push = v && (q.size() < DEPTH);
    m_out   = BUBBLE;
    m_issue = 1'b0;
    if (do_pop) begin
      hd = q.pop_front();
      if (!hd[7] && (hd[6:4] == 3'd3 || hd[6:4] == 3'd7 || cf)) begin
        if (m_drop < CNT_MAX) m_drop++;
      end else begin
        m_out   = hd;
        m_issue = 1'b1;
        if (m_icnt < CNT_MAX) m_icnt++;
      end
    end
    if (do_push) q.push_back(w);
    #1;
    compare_all(name);
  endtask

  typedef struct {
    logic       v;
    logic [7:0] w;
    logic       h;
    logic       cf;
    logic [7:0] out;
    logic       iss;
    int         lvl;
    int         drp;
    int         icn;
  } vec_t;

  vec_t tbl[9];

  initial begin
    // Directed vectors from reset: ADD issue, two invalid drops, cache-full drop vs mode-1 issue.
    tbl[0] = '{1'b1, 8'h05, 1'b0, 1'b0, BUBBLE, 1'b0, 1, 0, 0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h05,  1'b1, 0, 0, 1};
    tbl[2] = '{1'b1, 8'h35, 1'b0, 1'b0, BUBBLE, 1'b0, 1, 0, 1};
    tbl[3] = '{1'b1, 8'h75, 1'b0, 1'b0, BUBBLE, 1'b0, 1, 1, 1};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, BUBBLE, 1'b0, 0, 2, 1};
    tbl[5] = '{1'b1, 8'h12, 1'b0, 1'b1, BUBBLE, 1'b0, 1, 2, 1};
    tbl[6] = '{1'b1, 8'h80, 1'b0, 1'b1, BUBBLE, 1'b0, 1, 3, 1};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h80,  1'b1, 0, 3, 2};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, BUBBLE, 1'b0, 0, 3, 2};

    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_word  = 8'h00;
    hold         = 1'b0;
    cache_full   = 1'b0;
    model_reset();
    #12;
    check("reset_out",   {mode, opCode, value}, BUBBLE);
    check("reset_issue", issue, 1'b0);
    check("reset_level", fifo_level, 0);
    check("reset_ready", bus.in_ready, 1'b1);
    check("reset_cnts",  {drop_cnt, issue_cnt}, 0);
    #5 reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      step("tbl_model", tbl[i].v, tbl[i].w, tbl[i].h, tbl[i].cf);
      check($sformatf("tbl%0d_out", i),   {mode, opCode, value}, tbl[i].out);
      check($sformatf("tbl%0d_issue", i), issue, tbl[i].iss);
      check($sformatf("tbl%0d_level", i), fifo_level, tbl[i].lvl);
      check($sformatf("tbl%0d_drop", i),  drop_cnt, tbl[i].drp);
      check($sformatf("tbl%0d_icnt", i),  issue_cnt, tbl[i].icn);
    end

    // Hold with nine offered words: eight fit, the ninth is refused.
    for (int i = 0; i < 9; i++) step("hold_fill", 1'b1, 8'h80 + 8'(i), 1'b1, 1'b0);
    check("hold_full_level", fifo_level, DEPTH);
    check("hold_full_ready", bus.in_ready, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step("drain", 1'b0, 8'h00, 1'b0, 1'b0);
      check($sformatf("drain%0d_word", i), {mode, opCode, value}, 8'h80 + 8'(i));
      check($sformatf("drain%0d_issue", i), issue, 1'b1);
    end
    check("drain_level", fifo_level, 0);

    // Full FIFO: pop with a refused push, then push and pop together.
    for (int i = 0; i < 8; i++) step("full_fill", 1'b1, 8'h90 + 8'(i), 1'b1, 1'b0);
    step("full_pop", 1'b1, 8'hA0, 1'b0, 1'b0);
    check("full_refuse_level", fifo_level, 7);
    check("full_refuse_word", {mode, opCode, value}, 8'h90);
    step("full_both", 1'b1, 8'hA1, 1'b0, 1'b0);
    check("full_both_level", fifo_level, 7);
    for (int i = 0; i < 7; i++) step("full_drain", 1'b0, 8'h00, 1'b0, 1'b0);
    check("full_last_word", {mode, opCode, value}, 8'hA1);
    check("full_drain_level", fifo_level, 0);

    // Asynchronous reset between edges with five queued words.
    for (int i = 0; i < 5; i++) step("rst_fill", 1'b1, 8'h81 + 8'(i), 1'b1, 1'b0);
    check("rst_pre_level", fifo_level, 5);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("rst_async_level", fifo_level, 0);
    check("rst_async_issue", issue, 1'b0);
    check("rst_async_out",   {mode, opCode, value}, BUBBLE);
    check("rst_async_cnts",  {drop_cnt, issue_cnt}, 0);
    check("rst_async_ready", bus.in_ready, 1'b1);
    #2 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("rst_after", 1'b0, 8'h00, 1'b0, 1'b0);
      check($sformatf("rst_after%0d_issue", i), issue, 1'b0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), 8'($urandom),
           ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    // Drive both counters into saturation.
    for (int i = 0; i < 600; i++) begin
      step("sat", 1'b1, (i % 2 == 0) ? 8'h80 : 8'h35, 1'b0, 1'b0);
    end
    check("sat_drop", drop_cnt, CNT_MAX);
    check("sat_icnt", issue_cnt, CNT_MAX);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_feeder.md
INSTR_FEEDER -- requirements
Module: instr_feeder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, FIFO entry count (power of two, 2..32).
REQ-002 The block SHALL have parameter CNT_W, default 8, width of the drop/issue counters.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset; reset=0 forces the reset state immediately, independent of clk.
REQ-005 in_valid  input  1  upstream presents a packed instruction word.
REQ-006 in_word  input  8  packed word: [7]=mode, [6:4]=opCode, [3:0]=value.
REQ-007 in_ready  output  1  block accepts in_word on a posedge where in_valid=1 and in_ready=1.
REQ-008 hold  input  1  when 1, no FIFO pop and a bubble is issued.
REQ-009 cache_full  input  1  cacheFull fed back from the downstream calculator.
REQ-010 mode  output  1  registered mode to the calculator.
REQ-011 opCode  output  3  registered opCode to the calculator.
REQ-012 value  output  4  registered value to the calculator.
REQ-013 issue  output  1  registered; 1 when mode/opCode/value carry a real instruction this cycle.
REQ-014 drop_cnt  output  CNT_W  saturating count of words discarded before issue.
REQ-015 issue_cnt  output  CNT_W  saturating count of words issued with issue=1.
REQ-016 fifo_level  output  clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

Function
REQ-017 FIFO SHALL be DEPTH x 8 bits, circular read/write pointers, wrap modulo DEPTH.
REQ-018 in_ready SHALL equal (fifo_level < DEPTH); when full, a push is refused even if a pop occurs in the same cycle.
REQ-019 Push and pop in the same cycle SHALL leave fifo_level unchanged.
REQ-020 Pop SHALL occur on a posedge when fifo_level>0 and hold=0; exactly one word per cycle.
REQ-021 Popped word SHALL be classified: DROP_INV if mode=0 and opCode in {011,111}; DROP_FULL if mode=0 and cache_full=1 at that edge; otherwise ISSUE.
REQ-022 ISSUE SHALL register the word onto mode/opCode/value with issue=1, one cycle after the pop edge; issue_cnt increments.
REQ-023 DROP_INV and DROP_FULL SHALL register a bubble and increment drop_cnt.
REQ-024 Bubble encoding SHALL be mode=0, opCode=3'b011, value=0, issue=0 (downstream treats it as no cache write).
REQ-025 Empty FIFO or hold=1 SHALL register a bubble; no counter changes.
REQ-026 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-027 Minimum latency in_word accept -> issue=1 SHALL be 2 clocks (push edge, pop edge, output valid after pop edge).
REQ-028 Word order SHALL be preserved; drops do not reorder survivors.
REQ-029 Mode-1 words SHALL never be dropped regardless of cache_full.
REQ-030 Block state SHALL be: FIFO contents, pointers, level, output regs, counters; no other FSM.

Reset
REQ-031 reset=0 SHALL asynchronously clear pointers, fifo_level=0, drop_cnt=0, issue_cnt=0, issue=0, and drive the bubble on mode/opCode/value.
REQ-032 in_ready SHALL be 1 while reset=0 is released (FIFO empty); FIFO storage contents need not be cleared.
REQ-033 Reset asserted mid-operation SHALL discard all queued words; no issue pulse follows release without a new push.
REQ-034 First push SHALL be accepted on the first posedge with reset=1.

Verification
REQ-035 Push 0x05 (mode0 ADD val5), hold=0, cache_full=0 -> 2 clocks later mode=0, opCode=000, value=5, issue=1; issue_cnt=1.
REQ-036 Push 0x35 then 0x75 -> both dropped, bubbles only, drop_cnt=2, issue_cnt=0.
REQ-037 cache_full=1, push 0x12 then 0x80 -> 0x12 dropped (drop_cnt=1), 0x80 issued as mode=1, opCode=000, issue=1.
REQ-038 hold=1, push 9 words -> 8 accepted, in_ready=0, fifo_level=8; release hold -> 8 issues in order over 8 consecutive cycles, level returns 0.
REQ-039 Full FIFO with in_valid=1 and pop same cycle -> push refused, level 7; next cycle push accepted, level stays 7.
REQ-040 reset=0 pulsed between edges with level=5 -> level=0, issue=0, bubble outputs immediately, counters 0.
